// File: rtl/taxi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : taxi_pkg
// Description : Shared types, limits and default tariff for the taxi meter.
// Revision    : 1.0 - initial release
// ============================================================================
package taxi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned          FARE_W   = 14;
    localparam logic [FARE_W-1:0]    FARE_MAX = 14'd9999;
    localparam logic [3:0]           DP_MASK  = 4'b0010;

    localparam int DEF_BASE_FARE = 80;
    localparam int DEF_BASE_DIST = 30;
    localparam int DEF_STEP_FEE  = 2;
    localparam int DEF_WAIT_SEC  = 60;
    localparam int DEF_WAIT_FEE  = 10;

    // Saturating add: any sum above the display limit clamps to the limit.
    function automatic logic [FARE_W-1:0] sat_add(
        input logic [FARE_W-1:0] a,
        input logic [FARE_W-1:0] b
    );
        logic [FARE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, FARE_MAX}) ? FARE_MAX : s[FARE_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fare_calc_if.sv
`default_nettype none
// ============================================================================
// Module      : fare_calc_if
// Description : Trip-counter inputs and display-mux outputs of the fare stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fare_calc_if;
    logic        hire;
    logic        km_tick;
    logic        sec_tick;
    logic [15:0] price;
    logic [3:0]  point;
    logic        running;
    logic        busy;

    modport master (
        output hire, km_tick, sec_tick,
        input  price, point, running, busy
    );

    modport slave (
        input  hire, km_tick, sec_tick,
        output price, point, running, busy
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble, one bit per cycle, 14b -> 4 BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import taxi_pkg::*;
(
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 i_start,
    input  wire  [FARE_W-1:0]   i_bin,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_bcd
);

    localparam logic [3:0] c_last = 4'(FARE_W);

    logic              r_busy;
    logic [3:0]        r_cnt;
    logic [FARE_W-1:0] r_bin;
    logic [15:0]       r_bcd;
    logic [15:0]       w_adj;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                      r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
            r_bin  <= '0;
            r_bcd  <= 16'h0000;
        end else if (r_busy) begin
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end else begin
                r_bcd <= {w_adj[14:0], r_bin[FARE_W-1]};
                r_bin <= {r_bin[FARE_W-2:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
            end
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_bin  <= i_bin;
            r_bcd  <= 16'h0000;
            r_cnt  <= 4'd0;
        end
    end

    // done is high in the last busy cycle so the consumer captures on the same edge busy drops
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == c_last);
    assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/fare_calc.sv
`default_nettype none
// ============================================================================
// Module      : fare_calc
// Description : Taxi meter FSM, distance/wait counters, fare and BCD price.
// Revision    : 1.0 - initial release
// ============================================================================
module fare_calc
    import taxi_pkg::*;
#(
    parameter int BASE_FARE = DEF_BASE_FARE,
    parameter int BASE_DIST = DEF_BASE_DIST,
    parameter int STEP_FEE  = DEF_STEP_FEE,
    parameter int WAIT_SEC  = DEF_WAIT_SEC,
    parameter int WAIT_FEE  = DEF_WAIT_FEE
)(
    input  wire         clk,
    input  wire         sys_reset_n,
    fare_calc_if.slave  bus
);

    localparam int WAIT_W = $clog2(WAIT_SEC + 1);

    localparam logic [FARE_W-1:0] c_base_fare = FARE_W'(BASE_FARE);
    localparam logic [FARE_W-1:0] c_base_dist = FARE_W'(BASE_DIST);
    localparam logic [FARE_W-1:0] c_step_fee  = FARE_W'(STEP_FEE);
    localparam logic [FARE_W-1:0] c_wait_fee  = FARE_W'(WAIT_FEE);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(WAIT_SEC - 1);

    state_t             r_state, w_state_nxt;
    logic               r_hire_d;
    logic [FARE_W-1:0]  r_fare, w_fare_nxt;
    logic [FARE_W-1:0]  r_dist, w_dist_nxt;
    logic [WAIT_W-1:0]  r_wait, w_wait_nxt;
    logic [FARE_W-1:0]  r_last;
    logic [15:0]        r_price;

    logic               w_rise, w_fall;
    logic [FARE_W-1:0]  w_dist_inc;
    logic               w_start, w_busy, w_done;
    logic [15:0]        w_bcd;

    assign w_rise     = bus.hire & ~r_hire_d;
    assign w_fall     = ~bus.hire & r_hire_d;
    assign w_dist_inc = (r_dist == FARE_MAX) ? r_dist : r_dist + FARE_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_fare_nxt  = r_fare;
        w_dist_nxt  = r_dist;
        w_wait_nxt  = r_wait;
        case (r_state)
            IDLE, HOLD: begin
                if (w_rise) begin
                    w_state_nxt = RUN;
                    w_fare_nxt  = c_base_fare;
                    w_dist_nxt  = '0;
                    w_wait_nxt  = '0;
                end
            end
            RUN: begin
                if (w_fall) begin
                    w_state_nxt = HOLD;
                end else if (bus.km_tick) begin
                    // Movement restarts the waiting period even if a second ticks too
                    w_dist_nxt = w_dist_inc;
                    w_wait_nxt = '0;
                    if (w_dist_inc > c_base_dist)
                        w_fare_nxt = sat_add(r_fare, c_step_fee);
                end else if (bus.sec_tick) begin
                    if (r_wait == c_wait_last) begin
                        w_wait_nxt = '0;
                        w_fare_nxt = sat_add(r_fare, c_wait_fee);
                    end else begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state  <= IDLE;
            r_hire_d <= 1'b0;
            r_fare   <= '0;
            r_dist   <= '0;
            r_wait   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hire_d <= bus.hire;
            r_fare   <= w_fare_nxt;
            r_dist   <= w_dist_nxt;
            r_wait   <= w_wait_nxt;
        end
    end

    // r_last holds the fare handed to the converter, so a change mid-conversion re-triggers later
    assign w_start = ~w_busy && (r_fare != r_last);

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_last  <= '0;
            r_price <= 16'h0000;
        end else begin
            if (w_start)
                r_last <= r_fare;
            if (w_done)
                r_price <= w_bcd;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (sys_reset_n),
        .i_start (w_start),
        .i_bin   (r_fare),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    assign bus.price   = r_price;
    assign bus.point   = DP_MASK;
    assign bus.running = (r_state == RUN);
    assign bus.busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fare_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fare_calc
// Description : Scoreboard bench for fare_calc with directed tick sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fare_calc;

    logic clk = 1'b0;
    logic sys_reset_n;
    always #5 clk = ~clk;

    fare_calc_if bus();

    fare_calc dut (
        .clk         (clk),
        .sys_reset_n (sys_reset_n),
        .bus         (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    bit          mon_off = 1'b1;
    logic        prev_busy = 1'b0;
    logic [15:0] mon_exp;

    // Monitor: every completed conversion must match the oldest expected price
    always @(negedge clk) begin
        if (sys_reset_n && !mon_off && prev_busy && !bus.busy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL conv_unexpected: price=%h required=none", bus.price);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.price !== mon_exp) begin
                    bad++;
                    $display("FAIL conv_price: price=%h required=%h", bus.price, mon_exp);
                end
            end
        end
        prev_busy = bus.busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic km(input int n);
        repeat (n) begin
            @(negedge clk) bus.km_tick = 1'b1;
            @(negedge clk) bus.km_tick = 1'b0;
        end
    endtask

    task automatic sec(input int n);
        repeat (n) begin
            @(negedge clk) bus.sec_tick = 1'b1;
            @(negedge clk) bus.sec_tick = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic [15:0] step_exp [5] = '{16'h0082, 16'h0084, 16'h0086, 16'h0088, 16'h0090};

    initial begin
        int n;
        sys_reset_n  = 1'b0;
        bus.hire     = 1'b0;
        bus.km_tick  = 1'b0;
        bus.sec_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_price",   bus.price,   16'h0000);
        check("rst_point",   bus.point,   4'b0010);
        check("rst_running", bus.running, 1'b0);
        check("rst_busy",    bus.busy,    1'b0);
        sys_reset_n = 1'b1;
        mon_off     = 1'b0;
        repeat (2) @(negedge clk);

        // Hire start: base fare after a 16-cycle conversion
        bus.hire = 1'b1;
        exp_q.push_back(16'h0080);
        @(posedge clk); #1;
        check("running_rise", bus.running, 1'b1);
        n = 1;
        while (bus.price !== 16'h0080 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency_edges", n, 17);
        check("point", bus.point, 4'b0010);
        drain("drain_base");

        km(30);
        check("base_dist_price", bus.price, 16'h0080);
        check("base_dist_busy",  bus.busy,  1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(step_exp[i]);
            km(1);
            drain("drain_step");
        end
        check("tick35_price", bus.price, 16'h0090);

        // Waiting charge after 60 quiet seconds
        sec(59);
        check("wait59_price", bus.price, 16'h0090);
        exp_q.push_back(16'h0100);
        sec(1);
        drain("drain_wait");

        // km_tick at second 59 restarts the waiting period
        sec(59);
        exp_q.push_back(16'h0102);
        km(1);
        drain("drain_km59");
        sec(59);
        check("restart_price", bus.price, 16'h0102);
        exp_q.push_back(16'h0112);
        sec(1);
        drain("drain_restart");

        // Coincident km/sec tick at second 60: only the step fee
        sec(59);
        exp_q.push_back(16'h0114);
        @(negedge clk) begin bus.km_tick = 1'b1; bus.sec_tick = 1'b1; end
        @(negedge clk) begin bus.km_tick = 1'b0; bus.sec_tick = 1'b0; end
        drain("drain_coinc");
        sec(59);
        check("coinc_price", bus.price, 16'h0114);
        exp_q.push_back(16'h0124);
        sec(1);
        drain("drain_coinc_wait");

        // Saturation
        mon_off = 1'b1;
        km(5000);
        repeat (40) @(negedge clk);
        check("sat_price", bus.price, 16'h9999);
        check("sat_busy",  bus.busy,  1'b0);
        mon_off = 1'b0;
        km(10);
        sec(60);
        repeat (20) @(negedge clk);
        check("sat_hold_price", bus.price, 16'h9999);

        // Hire falls: frozen fare
        @(negedge clk) bus.hire = 1'b0;
        @(posedge clk); #1;
        check("running_fall", bus.running, 1'b0);
        km(20);
        sec(70);
        check("hold_price",   bus.price,   16'h9999);
        check("hold_busy",    bus.busy,    1'b0);
        check("hold_running", bus.running, 1'b0);

        // HOLD -> RUN, then reset in the middle of the conversion
        @(negedge clk) bus.hire = 1'b1;
        n = 0;
        while (bus.busy !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("rehire_busy",    bus.busy,    1'b1);
        check("rehire_running", bus.running, 1'b1);
        repeat (5) @(negedge clk);
        mon_off     = 1'b1;
        sys_reset_n = 1'b0;
        #1;
        check("midrst_price",   bus.price,   16'h0000);
        check("midrst_busy",    bus.busy,    1'b0);
        check("midrst_running", bus.running, 1'b0);
        bus.hire = 1'b0;
        @(negedge clk);
        sys_reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("postrst_price", bus.price, 16'h0000);
        check("postrst_busy",  bus.busy,  1'b0);
        check("queue_empty",   exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fare_calc.md
# fare_calc

Taxi fare computation stage sitting between the trip counters and the display mux. It consumes distance ticks (0.1 km each) and second ticks, applies base fare, per-distance and waiting charges, and produces a 4-digit packed-BCD price with a fixed decimal point. Its outputs drive the mux price channel, which otherwise carries a constant.

## Interface

Parameters (all fares in tenths of a yuan, distances in tenths of a km):
- BASE_FARE, 80, fare charged at hire start (8.0)
- BASE_DIST, 30, distance covered by base fare (3.0 km)
- STEP_FEE, 2, charge per 0.1 km beyond BASE_DIST (0.2)
- WAIT_SEC, 60, consecutive tick-free seconds per waiting charge
- WAIT_FEE, 10, charge per completed waiting period (1.0)

Ports:
- clk  in  1  system clock
- sys_reset_n  in  1  asynchronous, active-low reset
- hire  in  1  level, 1 = meter running; synchronous to clk, debounced upstream
- km_tick  in  1  one-cycle pulse per 0.1 km travelled
- sec_tick  in  1  one-cycle pulse per elapsed second
- price  out  16  packed BCD fare, 4 digits, tenths in [3:0]
- point  out  4  decimal-point mask for the display, constant 4'b0010
- running  out  1  1 while in RUN
- busy  out  1  1 while a BCD conversion is in flight

## Operation

- States: IDLE (post-reset), RUN, HOLD.
- IDLE/HOLD -> RUN on hire rising (hire=1, previous sample 0): fare=BASE_FARE, dist=0, wait_cnt=0.
- RUN -> HOLD on hire falling: fare frozen, price keeps the final fare until the next hire rise. Ticks are ignored in IDLE and HOLD.
- RUN, km_tick: dist = dist+1, saturating at 9999. If the new dist > BASE_DIST: fare += STEP_FEE. wait_cnt cleared.
- RUN, sec_tick without km_tick: wait_cnt+1. On reaching WAIT_SEC: fare += WAIT_FEE, wait_cnt=0.
- km_tick and sec_tick in the same cycle: km_tick wins, wait_cnt cleared, no waiting charge.
- fare is 14-bit binary and saturates at 9999 (999.9). Any add that would exceed 9999 yields 9999.
- Conversion is triggered when fare differs from the last converted value and the converter is idle. The conversion uses the fare value latched at start.
- A fare change during a conversion does not abort it. A new conversion starts the cycle after done.
- price updates atomically on done and never shows a partial value.

## Timing

- Reset values: state IDLE, fare 0, dist 0, wait_cnt 0, price 16'h0000, point 4'b0010, running 0, busy 0.
- Tick sampled at edge 0: fare updated at edge 0.
- Converter load at edge 1 (busy=1), 14 shift edges 2–15, price and busy=0 at edge 16. Latency is 16 cycles.
- Back-to-back changes: the final price appears no later than 32 cycles after the last fare change.
- running follows state with 0 cycles of extra delay (it is a registered state decode).
- Reset asserted mid-conversion: immediate return to the reset values. The partial result is discarded.

## Structure

- Shared package (taxi_pkg): state enum {IDLE, RUN, HOLD}, FARE_MAX=9999, FARE_W=14, DP_MASK=4'b0010, default fare parameters.
- One sub-module, bin2bcd_seq:
  - Sequential double-dabble with a 14-bit binary input and 16-bit BCD output.
  - Ports: start, busy, done pulse.
- fare_calc holds the FSM, the counters, the fare accumulator and the conversion trigger.

## Test plan

- Reset then hire=1 -> running=1 at the next edge, price=16'h0080 16 cycles after the rise, point=4'b0010.
- 30 km_ticks -> price stays 16'h0080. The 31st tick -> 16'h0082. The 35th tick -> 16'h0090.
- 60 sec_ticks with no km_tick -> +1.0 (e.g. 16'h0080 -> 16'h0090). A km_tick at second 59 -> no charge and wait_cnt restarts.
- km_tick coincident with the 60th sec_tick -> only STEP_FEE applied (if past BASE_DIST), no WAIT_FEE.
- Force fare near the limit (about 5000 km_ticks) -> price saturates at 16'h9999 and does not wrap.
- hire falls -> running=0 and price frozen despite further ticks. sys_reset_n pulsed during busy=1 -> price=16'h0000, busy=0 immediately.
